// File: rtl/cnn_sched_pkg.sv
// Shared types and widths for the CNN image scheduler: state encoding,
// bus widths and the in-flight counter update helper.
package cnn_sched_pkg;

  localparam int unsigned CNN_RES_W = 1024;
  localparam int unsigned CLASS_W   = 160;
  localparam int unsigned PIX_W     = 64;
  localparam int unsigned CNT_W     = 32;
  localparam int unsigned INFL_W    = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FEED = 1'b1
  } sched_state_e;

  typedef logic [CLASS_W-1:0] class_vec_t;

  // Net in-flight change: an image finishing and a result arriving together cancel out.
  function automatic logic [INFL_W-1:0] infl_next(input logic [INFL_W-1:0] cur,
                                                  input logic              inc,
                                                  input logic              dec);
    logic [INFL_W-1:0] nxt;
    nxt = cur;
    if (inc && !dec) begin
      nxt = cur + INFL_W'(1);
    end else if (dec && !inc) begin
      nxt = cur - INFL_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/cnn_img_sched_if.sv
// Scheduler bus: input FIFO, CNN feed/result, class-vector output and status.
// slave = scheduler side, master = environment side.
interface cnn_img_sched_if;
  import cnn_sched_pkg::*;

  logic                 enable;
  logic                 fifo_prog_empty;
  logic                 fifo_valid;
  logic                 fifo_rd_en;
  logic                 cnn_in_valid;
  logic                 cnn_in_ready;
  logic                 cnn_out_valid;
  logic [CNN_RES_W-1:0] cnn_out_data;
  logic                 res_valid;
  logic [CLASS_W-1:0]   res_data;
  logic                 res_ready;
  logic [CNT_W-1:0]     img_in_cnt;
  logic [CNT_W-1:0]     img_out_cnt;
  logic [INFL_W-1:0]    inflight;
  logic                 err_ovf;
  logic                 err_spur;
  logic [CNT_W-1:0]     stall_cnt;

  modport slave (
    input  enable, fifo_prog_empty, fifo_valid, cnn_in_ready,
           cnn_out_valid, cnn_out_data, res_ready,
    output fifo_rd_en, cnn_in_valid, res_valid, res_data,
           img_in_cnt, img_out_cnt, inflight, err_ovf, err_spur, stall_cnt
  );

  modport master (
    output enable, fifo_prog_empty, fifo_valid, cnn_in_ready,
           cnn_out_valid, cnn_out_data, res_ready,
    input  fifo_rd_en, cnn_in_valid, res_valid, res_data,
           img_in_cnt, img_out_cnt, inflight, err_ovf, err_spur, stall_cnt
  );

endinterface

// File: rtl/cnn_sched_resbuf.sv
// Two-entry class-vector FIFO; a push into a full buffer is accepted only
// when the head is popped in the same cycle.
module cnn_sched_resbuf
  import cnn_sched_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic       i_push,
  input  class_vec_t i_data,
  input  logic       i_pop,
  output class_vec_t o_data,
  output logic       o_full,
  output logic       o_empty
);

  class_vec_t r_mem [2];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_cnt;
  logic       w_push;
  logic       w_pop;

  assign w_pop   = i_pop & (r_cnt != 2'd0);
  assign w_push  = i_push & ((r_cnt != 2'd2) | w_pop);
  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);
  assign o_data  = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (srst) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_push) begin
        r_wptr <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage carries no reset; the read side is gated by o_empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

endmodule

// File: rtl/cnn_img_sched.sv
// CNN image scheduler: feeds whole images from the input FIFO while the
// in-flight limit allows, buffers class vectors. CNN_SCHED_STATS_EN adds stall_cnt.
module cnn_img_sched
  import cnn_sched_pkg::*;
#(
  parameter int unsigned IMG_BEATS    = 1024,
  parameter int unsigned MAX_INFLIGHT = 2,
  parameter int unsigned CLASS_LSB    = 864
) (
  input logic            clk,
  input logic            srst,
  cnn_img_sched_if.slave sched_bus
);

  localparam int unsigned       BEAT_W    = (IMG_BEATS > 1) ? $clog2(IMG_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(IMG_BEATS - 1);
  localparam logic [INFL_W-1:0] MAX_INFL  = INFL_W'(MAX_INFLIGHT);
  localparam logic [0:0]        S_IDLE    = 1'(ST_IDLE);
  localparam logic [0:0]        S_FEED    = 1'(ST_FEED);

  logic [0:0]        r_state;
  logic [BEAT_W-1:0] r_beat;
  logic [INFL_W-1:0] r_inflight;
  logic [CNT_W-1:0]  r_img_in_cnt;
  logic [CNT_W-1:0]  r_img_out_cnt;
  logic              r_err_ovf;
  logic              r_err_spur;

  logic [0:0]        w_state_nxt;
  logic              w_start;
  logic              w_last;
  logic              w_cnn_in_valid;
  logic              w_fifo_rd_en;
  logic              w_dec;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  class_vec_t        w_class;
  class_vec_t        w_res_data;
  logic              w_unused;

  assign w_class  = sched_bus.cnn_out_data[CLASS_LSB +: CLASS_W];
  // Result bits outside the class field are intentionally ignored.
  assign w_unused = ^sched_bus.cnn_out_data;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the combinational feed handshake.
  always_comb begin
    w_state_nxt    = r_state;
    w_start        = 1'b0;
    w_last         = 1'b0;
    w_cnn_in_valid = 1'b0;
    w_fifo_rd_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sched_bus.enable && !sched_bus.fifo_prog_empty && (r_inflight < MAX_INFL)) begin
          w_start     = 1'b1;
          w_state_nxt = S_FEED;
        end
      end
      S_FEED: begin
        w_cnn_in_valid = sched_bus.fifo_valid;
        w_fifo_rd_en   = sched_bus.fifo_valid & sched_bus.cnn_in_ready;
        if (w_fifo_rd_en && (r_beat == LAST_BEAT)) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_beat <= '0;
    end else if (w_start || w_last) begin
      r_beat <= '0;
    end else if (w_fifo_rd_en) begin
      r_beat <= r_beat + BEAT_W'(1);
    end
  end

  assign w_pop = !w_empty & sched_bus.res_ready;
  assign w_dec = sched_bus.cnn_out_valid & (r_inflight != '0);

  cnn_sched_resbuf u_resbuf (
    .clk     (clk),
    .srst    (srst),
    .i_push  (sched_bus.cnn_out_valid),
    .i_data  (w_class),
    .i_pop   (w_pop),
    .o_data  (w_res_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Status counters and sticky error flags.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_inflight    <= '0;
      r_img_in_cnt  <= '0;
      r_img_out_cnt <= '0;
      r_err_ovf     <= 1'b0;
      r_err_spur    <= 1'b0;
    end else begin
      r_inflight <= infl_next(r_inflight, w_last, w_dec);
      if (w_last) begin
        r_img_in_cnt <= r_img_in_cnt + CNT_W'(1);
      end
      if (w_pop) begin
        r_img_out_cnt <= r_img_out_cnt + CNT_W'(1);
      end
      if (sched_bus.cnn_out_valid && w_full && !w_pop) begin
        r_err_ovf <= 1'b1;
      end
      if (sched_bus.cnn_out_valid && (r_inflight == '0)) begin
        r_err_spur <= 1'b1;
      end
    end
  end

`ifdef CNN_SCHED_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_FEED) && !sched_bus.fifo_valid) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign sched_bus.stall_cnt = r_stall_cnt;
`else
  assign sched_bus.stall_cnt = '0;
`endif

  assign sched_bus.cnn_in_valid = w_cnn_in_valid;
  assign sched_bus.fifo_rd_en   = w_fifo_rd_en;
  assign sched_bus.res_valid    = !w_empty;
  assign sched_bus.res_data     = w_res_data;
  assign sched_bus.img_in_cnt   = r_img_in_cnt;
  assign sched_bus.img_out_cnt  = r_img_out_cnt;
  assign sched_bus.inflight     = r_inflight;
  assign sched_bus.err_ovf      = r_err_ovf;
  assign sched_bus.err_spur     = r_err_spur;

endmodule

// File: tb/tb_cnn_img_sched.sv
// Bench for cnn_img_sched: directed scenarios plus a randomized phase,
// results checked through an expected-class queue popped by a monitor.
module tb_cnn_img_sched;
  import cnn_sched_pkg::*;

  localparam int unsigned IMG_BEATS    = 4;
  localparam int unsigned MAX_INFLIGHT = 2;
  localparam int unsigned CLASS_LSB    = 864;
`ifdef CNN_SCHED_STATS_EN
  localparam int unsigned EXP_STALL = 5;
`else
  localparam int unsigned EXP_STALL = 0;
`endif

  logic clk;
  logic srst;

  cnn_img_sched_if bus ();

  cnn_img_sched #(
    .IMG_BEATS    (IMG_BEATS),
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .CLASS_LSB    (CLASS_LSB)
  ) dut (
    .clk       (clk),
    .srst      (srst),
    .sched_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  class_vec_t exp_q[$];

  // Reference model: buffer occupancy, images in flight, counts and sticky flags.
  int   m_occ = 0;
  int   m_occ_q = 0;
  int   m_inflight = 0;
  int   m_beats = 0;
  int   m_img_in = 0;
  int   m_pops = 0;
  logic m_ovf = 1'b0;
  logic m_spur = 1'b0;
  logic m_ovf_q = 1'b0;
  logic m_spur_q = 1'b0;
  logic cur_strobe = 1'b0;
  logic cur_pop = 1'b0;
  logic rand_phase = 1'b0;

  logic d_en, d_fpe, d_fv, d_rdy, d_rr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CNN_RES_W-1:0] rand_res();
    logic [CNN_RES_W-1:0] v;
    v = '0;
    for (int i = 0; i < int'(CNN_RES_W / 32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic zero_inputs();
    bus.enable          = 1'b0;
    bus.fifo_prog_empty = 1'b0;
    bus.fifo_valid      = 1'b0;
    bus.cnn_in_ready    = 1'b0;
    bus.cnn_out_valid   = 1'b0;
    bus.cnn_out_data    = '0;
    bus.res_ready       = 1'b0;
  endtask

  task automatic clear_model();
    exp_q.delete();
    m_occ = 0; m_occ_q = 0; m_inflight = 0; m_beats = 0; m_img_in = 0; m_pops = 0;
    m_ovf = 1'b0; m_spur = 1'b0; m_ovf_q = 1'b0; m_spur_q = 1'b0;
    cur_strobe = 1'b0; cur_pop = 1'b0;
  endtask

  // One clock of stimulus; the model predicts buffer acceptance and flags.
  task automatic step(input logic ov, input logic [CNN_RES_W-1:0] d);
    @(posedge clk); #1;
    bus.enable          = d_en;
    bus.fifo_prog_empty = d_fpe;
    bus.fifo_valid      = d_fv;
    bus.cnn_in_ready    = d_rdy;
    bus.cnn_out_valid   = ov;
    bus.cnn_out_data    = d;
    bus.res_ready       = d_rr;
    m_occ_q    = m_occ;
    m_ovf_q    = m_ovf;
    m_spur_q   = m_spur;
    cur_strobe = ov;
    cur_pop    = (m_occ > 0) && d_rr;
    if (ov) begin
      if (m_inflight == 0) m_spur = 1'b1;
      if (m_occ < 2 || cur_pop) begin
        exp_q.push_back(d[CLASS_LSB +: CLASS_W]);
        m_occ++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (cur_pop) begin
      m_occ--;
      m_pops++;
    end
  endtask

  task automatic idle_step();
    step(1'b0, '0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    srst = 1'b1;
    zero_inputs();
    clear_model();
    @(posedge clk); #1;
    srst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"},    64'(bus.fifo_rd_en), 64'd0);
    chk({tag, "_in_valid"}, 64'(bus.cnn_in_valid), 64'd0);
    chk({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
    chk({tag, "_img_in"},   64'(bus.img_in_cnt), 64'd0);
    chk({tag, "_img_out"},  64'(bus.img_out_cnt), 64'd0);
    chk({tag, "_inflight"}, 64'(bus.inflight), 64'd0);
    chk({tag, "_ovf"},      64'(bus.err_ovf), 64'd0);
    chk({tag, "_spur"},     64'(bus.err_spur), 64'd0);
    chk({tag, "_stall"},    64'(bus.stall_cnt), 64'd0);
  endtask

  // Step until the first accepted beat; returns 1 if seen within the budget.
  task automatic wait_beat(input int budget, output logic found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      idle_step();
      @(negedge clk);
      if (bus.fifo_rd_en === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Count consecutive accepted beats after the first one already seen.
  task automatic run_len(output int run);
    run = 1;
    for (int i = 0; i < 3 * IMG_BEATS; i++) begin
      idle_step();
      @(negedge clk);
      if (bus.fifo_rd_en !== 1'b1) break;
      run++;
    end
  endtask

  // Scoreboard monitor and model bookkeeping at the falling edge.
  always @(negedge clk) begin
    logic inc;
    class_vec_t e;
    inc = 1'b0;
    if (!srst) begin
      if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL res_extra: got %h with nothing expected", bus.res_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.res_data !== e) begin
            errors++;
            $display("FAIL res_data: got %h expected %h", bus.res_data, e);
          end
        end
      end
      if (rand_phase) begin
        chk("f_inflight",  64'(bus.inflight), 64'(m_inflight));
        chk("f_img_in",    64'(bus.img_in_cnt), 64'(m_img_in));
        chk("f_img_out",   64'(bus.img_out_cnt), 64'(m_pops - int'(cur_pop)));
        chk("f_spur",      64'(bus.err_spur), 64'(m_spur_q));
        chk("f_ovf",       64'(bus.err_ovf), 64'(m_ovf_q));
        chk("f_res_valid", 64'(bus.res_valid), 64'(m_occ_q > 0));
        chk("f_rd_en",     64'(bus.fifo_rd_en), 64'(bus.cnn_in_valid & bus.cnn_in_ready));
        chk("f_in_valid",  64'(bus.cnn_in_valid & ~bus.fifo_valid), 64'd0);
        if (bus.fifo_rd_en === 1'b1 && m_beats == 0)
          chk("f_cap", 64'(m_inflight < int'(MAX_INFLIGHT)), 64'd1);
      end
      if (bus.fifo_rd_en === 1'b1) begin
        m_beats++;
        if (m_beats == int'(IMG_BEATS)) begin
          m_beats = 0;
          m_img_in++;
          inc = 1'b1;
        end
      end
      if (cur_strobe && m_inflight > 0) m_inflight--;
      if (inc) m_inflight++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    int   run;
    int   seen;
    srst = 1'b1;
    zero_inputs();
    {d_en, d_fpe, d_fv, d_rdy, d_rr} = '0;
    repeat (2) @(posedge clk);

    // Reset state and back-to-back image feeding with one idle bubble.
    do_reset();
    @(negedge clk);
    check_zero("rst");
    d_en = 1'b1; d_fpe = 1'b0; d_fv = 1'b1; d_rdy = 1'b1; d_rr = 1'b1;
    wait_beat(8, found);
    chk("a_start", 64'(found), 64'd1);
    run_len(run);
    chk("a_run_len",  64'(run), 64'(IMG_BEATS));
    chk("a_bubble",   64'(bus.fifo_rd_en), 64'd0);
    chk("a_img_in",   64'(bus.img_in_cnt), 64'd1);
    chk("a_inflight", 64'(bus.inflight), 64'd1);
    idle_step();
    @(negedge clk);
    chk("a_restart", 64'(bus.fifo_rd_en), 64'd1);

    // In-flight limit holds the FSM idle until one result returns.
    for (int i = 0; i < 12; i++) begin
      idle_step();
      @(negedge clk);
      if (bus.inflight == 4'd2) break;
    end
    chk("b_full", 64'(bus.inflight), 64'd2);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      idle_step();
      @(negedge clk);
      seen += int'(bus.fifo_rd_en);
    end
    chk("b_hold",   64'(seen), 64'd0);
    chk("b_img_in", 64'(bus.img_in_cnt), 64'd2);
    step(1'b1, rand_res());
    idle_step();
    @(negedge clk);
    chk("b_dec", 64'(bus.inflight), 64'd1);
    wait_beat(6, found);
    chk("b_third_start", 64'(found), 64'd1);
    d_en = 1'b0;
    repeat (10) idle_step();

    // Three results into a two-entry buffer with the output stalled.
    do_reset();
    d_en = 1'b0; d_rr = 1'b0;
    repeat (3) step(1'b1, rand_res());
    repeat (2) idle_step();
    @(negedge clk);
    chk("c_ovf",       64'(bus.err_ovf), 64'd1);
    chk("c_spur",      64'(bus.err_spur), 64'd1);
    chk("c_res_valid", 64'(bus.res_valid), 64'd1);
    chk("c_inflight",  64'(bus.inflight), 64'd0);
    d_rr = 1'b1;
    repeat (4) idle_step();
    @(negedge clk);
    chk("c_img_out",   64'(bus.img_out_cnt), 64'd2);
    chk("c_empty",     64'(bus.res_valid), 64'd0);
    chk("c_drained",   64'(exp_q.size()), 64'd0);

    // Spurious result with nothing in flight is still delivered.
    do_reset();
    d_rr = 1'b1;
    step(1'b1, rand_res());
    repeat (2) idle_step();
    @(negedge clk);
    chk("s_spur",     64'(bus.err_spur), 64'd1);
    chk("s_ovf",      64'(bus.err_ovf), 64'd0);
    chk("s_inflight", 64'(bus.inflight), 64'd0);
    chk("s_img_out",  64'(bus.img_out_cnt), 64'd1);

    // Five stalled cycles mid-image; enable dropped without aborting.
    do_reset();
    d_en = 1'b1; d_fv = 1'b1; d_rdy = 1'b1; d_rr = 1'b1;
    wait_beat(8, found);
    chk("d_start", 64'(found), 64'd1);
    idle_step();
    @(negedge clk);
    chk("d_beat2", 64'(bus.fifo_rd_en), 64'd1);
    d_fv = 1'b0; d_en = 1'b0;
    repeat (5) idle_step();
    d_fv = 1'b1;
    for (int i = 0; i < 20; i++) begin
      idle_step();
      @(negedge clk);
      if (bus.img_in_cnt == 32'd1) break;
    end
    chk("d_img_done", 64'(bus.img_in_cnt), 64'd1);
    chk("d_stall",    64'(bus.stall_cnt), 64'(EXP_STALL));
    repeat (10) idle_step();
    @(negedge clk);
    chk("d_no_next", 64'(bus.img_in_cnt), 64'd1);

    // Reset after two beats abandons the image; next one needs all beats.
    do_reset();
    d_en = 1'b1; d_fv = 1'b1; d_rdy = 1'b1; d_rr = 1'b1;
    wait_beat(8, found);
    idle_step();
    @(negedge clk);
    chk("e_beat2", 64'(bus.fifo_rd_en), 64'd1);
    do_reset();
    @(negedge clk);
    check_zero("e_rst");
    wait_beat(8, found);
    chk("e_start", 64'(found), 64'd1);
    run_len(run);
    chk("e_run_len", 64'(run), 64'(IMG_BEATS));
    chk("e_img_in",  64'(bus.img_in_cnt), 64'd1);

    // Randomized traffic checked cycle by cycle against the model.
    do_reset();
    rand_phase = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      d_en  = ($urandom_range(7) != 0);
      d_fpe = ($urandom_range(7) == 0);
      d_fv  = ($urandom_range(3) != 0);
      d_rdy = ($urandom_range(3) != 0);
      d_rr  = ($urandom_range(2) != 0);
      if ((m_inflight > 0 && $urandom_range(5) == 0) || $urandom_range(199) == 0)
        step(1'b1, rand_res());
      else
        idle_step();
    end
    d_en = 1'b0; d_fv = 1'b1; d_rdy = 1'b1; d_rr = 1'b1;
    repeat (40) idle_step();
    @(negedge clk);
    chk("f_drain", 64'(exp_q.size()), 64'd0);
    rand_phase = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_img_sched.md
CNN_IMG_SCHED -- requirements
Module: cnn_img_sched

Interface
REQ-001 SHALL have parameter IMG_BEATS, default 1024, meaning the input beats (64-bit pixel words) per image.
REQ-002 SHALL have parameter MAX_INFLIGHT, default 2, meaning the maximum number of images fed but not yet resulted (1..15).
REQ-003 SHALL have parameter CLASS_LSB, default 864, meaning the lowest bit of the 160-bit class field within the 1024-bit CNN result.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port srst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port enable, input, 1 bit: permits starting new images.
REQ-007 SHALL have port fifo_prog_empty, input, 1 bit: input FIFO holds less than one image.
REQ-008 SHALL have port fifo_valid, input, 1 bit: input FIFO head valid.
REQ-009 SHALL have port fifo_rd_en, output, 1 bit: pop input FIFO.
REQ-010 SHALL have port cnn_in_valid, output, 1 bit: pixel beat to CNN valid.
REQ-011 SHALL have port cnn_in_ready, input, 1 bit: CNN accepts beat.
REQ-012 SHALL have port cnn_out_valid, input, 1 bit: single-cycle CNN result strobe.
REQ-013 SHALL have port cnn_out_data, input, 1024 bits: CNN result.
REQ-014 SHALL have port res_valid, output, 1 bit: class vector available.
REQ-015 SHALL have port res_data, output, 160 bits: class vector.
REQ-016 SHALL have port res_ready, input, 1 bit: output FIFO accepts.
REQ-017 SHALL have port img_in_cnt, output, 32 bits: images fully fed.
REQ-018 SHALL have port img_out_cnt, output, 32 bits: results delivered (res_valid&res_ready).
REQ-019 SHALL have port inflight, output, 4 bits: current in-flight count.
REQ-020 SHALL have port err_ovf, output, 1 bit: sticky, result dropped.
REQ-021 SHALL have port err_spur, output, 1 bit: sticky, result with inflight==0.
REQ-022 SHALL have port stall_cnt, output, 32 bits: FEED cycles with fifo_valid low.

Function
REQ-023 SHALL implement FSM states IDLE and FEED.
REQ-024 IDLE->FEED SHALL occur when enable & !fifo_prog_empty & (inflight < MAX_INFLIGHT), with beat counter cleared.
REQ-025 In FEED: cnn_in_valid=fifo_valid; fifo_rd_en=fifo_valid&cnn_in_ready; a beat is accepted when both are high. Both SHALL be 0 in IDLE.
REQ-026 Accepting beat IMG_BEATS-1 SHALL return the FSM to IDLE next cycle, increment img_in_cnt and increment inflight; one IDLE bubble minimum between images.
REQ-027 Deasserting enable in FEED SHALL NOT abort the image; it only blocks the next start.
REQ-028 cnn_out_valid SHALL push cnn_out_data[CLASS_LSB+159:CLASS_LSB] into a 2-entry result buffer and decrement inflight, with latency from strobe to res_valid of 1 cycle.
REQ-029 Simultaneous inflight increment and decrement SHALL leave inflight unchanged.
REQ-030 cnn_out_valid with inflight==0 SHALL set err_spur, still buffer the result, and leave inflight at 0.
REQ-031 cnn_out_valid with the buffer full and no pop in the same cycle SHALL set err_ovf and drop the new result; a push with a same-cycle pop while full SHALL succeed.
REQ-032 res_valid/res_data SHALL be stable until res_ready; order SHALL be FIFO.
REQ-033 Counters SHALL wrap modulo 2^32 silently.

Reset
REQ-034 srst SHALL force IDLE, beat counter 0, buffer empty, and all outputs 0 (res_valid, fifo_rd_en, cnn_in_valid, counters, inflight, err_ovf, err_spur, stall_cnt) on the next edge, including mid-image; a partially fed image is abandoned.

Configuration
REQ-035 With CNN_SCHED_STATS_EN defined, stall_cnt SHALL increment each FEED cycle with fifo_valid==0; without it stall_cnt SHALL be constant 0 and the counter logic absent.

Structure
REQ-036 Package cnn_sched_pkg SHALL hold the state enum, CNN_RES_W=1024, CLASS_W=160 and PIX_W=64.
REQ-037 The result buffer SHALL be sub-module cnn_sched_resbuf (2-entry, push/pop/full/empty).

Verification
REQ-038 IMG_BEATS=4, fifo_prog_empty=0, fifo_valid=1, cnn_in_ready=1, enable=1 -> 4 consecutive fifo_rd_en, then img_in_cnt=1, inflight=1, FEED restarts after one IDLE cycle.
REQ-039 MAX_INFLIGHT=2, no cnn_out_valid -> after 2 images FSM holds IDLE, inflight=2; one cnn_out_valid -> third image starts.
REQ-040 Three cnn_out_valid strobes with res_ready=0 -> first two buffered, err_ovf=1; then res_ready=1 -> exactly 2 results in order, img_out_cnt=2.
REQ-041 cnn_out_valid at reset with inflight=0 -> err_spur=1, inflight stays 0, result delivered.
REQ-042 fifo_valid low 5 cycles mid-image with CNN_SCHED_STATS_EN -> stall_cnt=5; without the macro -> 0.
REQ-043 srst after beat 2 of 4 -> all outputs 0 next cycle; new image restarts at beat 0.
